// File: rtl/dm_pkg.sv
// Shared encodings for the data-memory port arbiter: access sizes, FSM states
// and the memory's byte-enable patterns.
package dm_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;

  // One-hot byte lane for a byte access at the given word offset.
  function automatic logic [3:0] byte_be(input logic [1:0] offset);
    return 4'b0001 << offset;
  endfunction

endpackage

// File: rtl/dm_lane_ctrl.sv
// Combinational lane logic for one access: byte enables, alignment check and
// extraction/extension of the addressed lane from the memory read word.
module dm_lane_ctrl
  import dm_pkg::*;
#(
  parameter int width = 32
) (
  input  logic [1:0]       addr_lo,
  input  logic [1:0]       size,
  input  logic             sgn,
  input  logic [width-1:0] dout,
  output logic [3:0]       be,
  output logic             misaligned,
  output logic [width-1:0] rdata
);

  logic [7:0]  lane8;
  logic [15:0] lane16;

  // NOTE: every output of a combinational block gets a default before the case,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    be         = BE_NONE;
    misaligned = 1'b0;
    rdata      = '0;
    lane8      = dout[{addr_lo, 3'b000} +: 8];
    lane16     = addr_lo[1] ? dout[31:16] : dout[15:0];
    case (size)
      SZ_BYTE: begin
        be    = byte_be(addr_lo);
        rdata = {{(width-8){sgn & lane8[7]}}, lane8};
      end
      SZ_HALF: begin
        if (addr_lo[0]) begin
          misaligned = 1'b1;
        end else begin
          be    = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
          rdata = {{(width-16){sgn & lane16[15]}}, lane16};
        end
      end
      SZ_WORD: begin
        if (addr_lo != 2'd0) begin
          misaligned = 1'b1;
        end else begin
          be    = BE_WORD;
          rdata = dout;
        end
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Round-robin sharing of the single-port data memory between the MEM stage
// (port 0) and the debug loader (port 1); one access every three cycles.
module dm_port_arbiter
  import dm_pkg::*;
#(
  parameter int AddrWidth = 10,
  parameter int width     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [AddrWidth+1:0] addr0,
  input  logic [AddrWidth+1:0] addr1,
  input  logic [1:0]           size0,
  input  logic [1:0]           size1,
  input  logic                 sgn0,
  input  logic                 sgn1,
  input  logic [width-1:0]     wdata0,
  input  logic [width-1:0]     wdata1,
  output logic                 ack0,
  output logic                 ack1,
  output logic                 err0,
  output logic                 err1,
  output logic [width-1:0]     rdata0,
  output logic [width-1:0]     rdata1,
  output logic [AddrWidth-1:0] dm_addr,
  output logic [3:0]           dm_be,
  output logic [width-1:0]     dm_din,
  output logic                 dm_we,
  input  logic [width-1:0]     dm_dout
);

  state_e               state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic                 port_q, port_d;
  logic                 we_q, we_d;
  logic [AddrWidth+1:0] addr_q, addr_d;
  logic [1:0]           size_q, size_d;
  logic                 sgn_q, sgn_d;
  logic [width-1:0]     wdata_q, wdata_d;
  logic [width-1:0]     rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                 ack0_q, ack0_d, ack1_q, ack1_d;
  logic                 err0_q, err0_d, err1_q, err1_d;

  logic                 grant;
  logic                 access;
  logic [3:0]           lane_be;
  logic                 lane_mis;
  logic [width-1:0]     lane_rdata;

  dm_lane_ctrl #(.width(width)) u_lane (
    .addr_lo    (addr_q[1:0]),
    .size       (size_q),
    .sgn        (sgn_q),
    .dout       (dm_dout),
    .be         (lane_be),
    .misaligned (lane_mis),
    .rdata      (lane_rdata)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    we_d         = we_q;
    addr_d       = addr_q;
    size_d       = size_q;
    sgn_d        = sgn_q;
    wdata_d      = wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    err0_d       = 1'b0;
    err1_d       = 1'b0;
    grant        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          // Contention goes to the port that did not win last time.
          grant        = (req0 && req1) ? ~last_grant_q : req1;
          port_d       = grant;
          last_grant_d = grant;
          we_d         = grant ? we1    : we0;
          addr_d       = grant ? addr1  : addr0;
          size_d       = grant ? size1  : size0;
          sgn_d        = grant ? sgn1   : sgn0;
          wdata_d      = grant ? wdata1 : wdata0;
          state_d      = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        state_d = ST_DONE;
        if (port_q) begin
          ack1_d = 1'b1;
          err1_d = lane_mis;
          if (lane_mis)   rdata1_d = '0;
          else if (!we_q) rdata1_d = lane_rdata;
        end else begin
          ack0_d = 1'b1;
          err0_d = lane_mis;
          if (lane_mis)   rdata0_d = '0;
          else if (!we_q) rdata0_d = lane_rdata;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; the request latches are reset too, keeping the
  // memory-side outputs free of X after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      size_q       <= SZ_BYTE;
      sgn_q        <= 1'b0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      sgn_q        <= sgn_d;
      wdata_q      <= wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
    end
  end

  // Reset gates the strobe combinationally so an in-flight store never lands.
  assign access  = (state_q == ST_ACCESS) && !rst;
  assign dm_addr = access ? addr_q[AddrWidth+1:2] : '0;
  assign dm_be   = access ? lane_be : BE_NONE;
  assign dm_din  = access ? wdata_q : '0;
  assign dm_we   = access && we_q && !lane_mis;

  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign err0   = err0_q;
  assign err1   = err1_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

endmodule
